// File: rtl/reg_bank_pkg.sv
// ---------------------------------------------------------------------------
// reg_bank_pkg
// Shared definitions for the reg_bank register file:
//   src_e      - write source encoding (which load source won arbitration)
//   DEF_WIDTH  - default entry/data width
//   DEF_NREGS  - default number of entries
// ---------------------------------------------------------------------------
package reg_bank_pkg;

   typedef enum logic [1:0] {
      SRC_NONE = 2'd0,
      SRC_SE   = 2'd1,
      SRC_LDM  = 2'd2,
      SRC_ACC  = 2'd3
   } src_e;

   localparam int DEF_WIDTH = 16;
   localparam int DEF_NREGS = 2;

endpackage

// File: rtl/reg_bank_wsel.sv
// ---------------------------------------------------------------------------
// reg_bank_wsel
// Combinational write-source arbitration for reg_bank.
// Fixed priority: acc > load > se.
// Ports:
//   lacc, ldm, lse  in   write strobes (acc, load, se)
//   acc, load, se   in   candidate write data
//   we              out  any strobe high
//   wdata           out  data of the winning source (0 when none)
//   conflict        out  two or more strobes high in this cycle
// ---------------------------------------------------------------------------
module reg_bank_wsel
   import reg_bank_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             lacc,
   input  logic             ldm,
   input  logic             lse,
   input  logic [WIDTH-1:0] acc,
   input  logic [WIDTH-1:0] load,
   input  logic [WIDTH-1:0] se,
   output logic             we,
   output logic [WIDTH-1:0] wdata,
   output logic             conflict
);

   src_e src;

   always_comb begin
      src = SRC_NONE;
      if (lacc)      src = SRC_ACC;
      else if (ldm)  src = SRC_LDM;
      else if (lse)  src = SRC_SE;
   end

   always_comb begin
      wdata = '0;
      case (src)
         SRC_ACC: wdata = acc;
         SRC_LDM: wdata = load;
         SRC_SE:  wdata = se;
         default: wdata = '0;
      endcase
   end

   assign we = (src != SRC_NONE);

   // At least two of three strobes high.
   assign conflict = (lacc & ldm) | (lacc & lse) | (ldm & lse);

endmodule

// File: rtl/reg_bank.sv
// ---------------------------------------------------------------------------
// reg_bank
// NREGS x WIDTH register file for the accumulator datapath with three
// prioritised load sources, two registered read ports and per-entry
// written-since-reset flags.
// Optional feature macro: REG_BANK_BYPASS_EN - when defined, a read on the
// same edge as a write to the same in-range entry returns the new data.
// Ports:
//   clk                   in   rising-edge clock
//   rst                   in   asynchronous active-low reset
//   lacc, ldm, lse        in   write strobes (priority acc > load > se)
//   wr_addr               in   destination entry
//   acc, load, se         in   write data sources
//   rd_addr_a, rd_addr_b  in   read addresses
//   rd_data_a, rd_data_b  out  registered read data (0 when out of range)
//   rd_vld_a, rd_vld_b    out  addressed entry written since reset
//   wr_conflict           out  registered pulse: more than one strobe high
// ---------------------------------------------------------------------------
module reg_bank
   import reg_bank_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int NREGS = DEF_NREGS
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     lacc,
   input  logic                     ldm,
   input  logic                     lse,
   input  logic [$clog2(NREGS)-1:0] wr_addr,
   input  logic [WIDTH-1:0]         acc,
   input  logic [WIDTH-1:0]         load,
   input  logic [WIDTH-1:0]         se,
   input  logic [$clog2(NREGS)-1:0] rd_addr_a,
   input  logic [$clog2(NREGS)-1:0] rd_addr_b,
   output logic [WIDTH-1:0]         rd_data_a,
   output logic [WIDTH-1:0]         rd_data_b,
   output logic                     rd_vld_a,
   output logic                     rd_vld_b,
   output logic                     wr_conflict
);

   localparam int AW = $clog2(NREGS);
   // One extra bit so the range check also works for power-of-2 NREGS.
   localparam logic [AW:0] NREGS_W = (AW+1)'(NREGS);

   logic [WIDTH-1:0] mem [NREGS];
   logic [NREGS-1:0] wr_flag;

   logic             we;
   logic [WIDTH-1:0] wdata;
   logic             conflict;
   logic             wr_in;
   logic             rd_in_a;
   logic             rd_in_b;

   reg_bank_wsel #(.WIDTH(WIDTH)) u_wsel (
      .lacc     (lacc),
      .ldm      (ldm),
      .lse      (lse),
      .acc      (acc),
      .load     (load),
      .se       (se),
      .we       (we),
      .wdata    (wdata),
      .conflict (conflict)
   );

   assign wr_in   = ({1'b0, wr_addr}   < NREGS_W);
   assign rd_in_a = ({1'b0, rd_addr_a} < NREGS_W);
   assign rd_in_b = ({1'b0, rd_addr_b} < NREGS_W);

   // Storage and written-since-reset flags.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NREGS; i++) mem[i] <= '0;
         wr_flag <= '0;
      end else if (we && wr_in) begin
         mem[wr_addr]     <= wdata;
         wr_flag[wr_addr] <= 1'b1;
      end
   end

   // Read registers sample the pre-write array contents; the optional
   // bypass overrides them with the data being written on the same edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_data_a <= '0;
         rd_vld_a  <= 1'b0;
         rd_data_b <= '0;
         rd_vld_b  <= 1'b0;
      end else begin
         if (rd_in_a) begin
            rd_data_a <= mem[rd_addr_a];
            rd_vld_a  <= wr_flag[rd_addr_a];
         end else begin
            rd_data_a <= '0;
            rd_vld_a  <= 1'b0;
         end
         if (rd_in_b) begin
            rd_data_b <= mem[rd_addr_b];
            rd_vld_b  <= wr_flag[rd_addr_b];
         end else begin
            rd_data_b <= '0;
            rd_vld_b  <= 1'b0;
         end
`ifdef REG_BANK_BYPASS_EN
         if (we && wr_in && (rd_addr_a == wr_addr)) begin
            rd_data_a <= wdata;
            rd_vld_a  <= 1'b1;
         end
         if (we && wr_in && (rd_addr_b == wr_addr)) begin
            rd_data_b <= wdata;
            rd_vld_b  <= 1'b1;
         end
`endif
      end
   end

   // Conflict is reported even when the write address is out of range.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) wr_conflict <= 1'b0;
      else      wr_conflict <= conflict;
   end

endmodule

// File: doc/reg_bank.md
# reg_bank

Parametrised multi-register file for the accumulator datapath. It generalises the two-entry x/y register pair to NREGS entries of WIDTH bits. It keeps the same three load sources with fixed priority (accumulator, memory load, sign-extend unit) and adds two independent registered read ports plus per-entry written-since-reset flags. It sits between the ALU/accumulator, the memory load path and the sign-extend unit, and feeds ALU operands.

## Interface
- WIDTH, 16, data width of every entry and data port
- NREGS, 2, number of entries; any value ≥ 2
- AW, $clog2(NREGS), localparam, address width

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- lacc  in  1  write strobe, source acc (highest priority)
- ldm  in  1  write strobe, source load
- lse  in  1  write strobe, source se (lowest priority)
- wr_addr  in  AW  destination entry
- acc  in  WIDTH  accumulator data
- load  in  WIDTH  memory load data
- se  in  WIDTH  sign-extended immediate
- rd_addr_a  in  AW  read port A address
- rd_addr_b  in  AW  read port B address
- rd_data_a  out  WIDTH  registered read data A
- rd_data_b  out  WIDTH  registered read data B
- rd_vld_a  out  1  entry addressed by A has been written since reset
- rd_vld_b  out  1  same for B
- wr_conflict  out  1  registered one-cycle pulse: more than one strobe was high

## Operation
- Write source select: lacc → acc; else ldm → load; else lse → se; none high → no write.
- Write: on posedge clk, if any strobe is high and wr_addr < NREGS, mem[wr_addr] ← selected data and wr_flag[wr_addr] ← 1.
- wr_addr ≥ NREGS (non-power-of-2 NREGS): write dropped, no flag set, wr_conflict still evaluated.
- Read: on every posedge, rd_data_x ← mem[rd_addr_x] and rd_vld_x ← wr_flag[rd_addr_x]. Reads are unconditional; there is no read enable.
- Out-of-range read address: rd_data_x ← 0, rd_vld_x ← 0.
- Both ports may address the same entry; each returns the identical value.
- wr_conflict ← (lacc+ldm+lse ≥ 2) each cycle. The write itself still follows priority.
- No other state; no FSM beyond the per-entry flag bits.

## Timing
- Reset (rst low, asynchronous): all mem entries 0, all wr_flag 0, rd_data_a/b = 0, rd_vld_a/b = 0, wr_conflict = 0. Takes effect immediately, independent of clk.
- Reset release: first active edge behaves normally. A strobe high on that edge writes.
- Write latency: data written at edge N is readable in the read register at edge N+1 and visible on rd_data at N+1.
- Read latency: one cycle from rd_addr to rd_data/rd_vld.
- Same-edge write and read of the same entry: read returns the pre-write (old) value unless the bypass is compiled in.
- Reset asserted mid-write: write is lost; entry stays 0 with flag 0.

## Configuration
- REG_BANK_BYPASS_EN defined: a read on the same edge as a write to the same in-range entry returns the new write data, and rd_vld is 1. The bypass applies to ports A and B independently.
- Not defined: read-old behaviour as above; no forwarding logic is generated.

## Structure
- Shared package reg_bank_pkg:
  - source encoding enum (SRC_NONE, SRC_SE, SRC_LDM, SRC_ACC)
  - default WIDTH/NREGS constants
- One sub-module, reg_bank_wsel: combinational priority encoder plus data mux, producing write enable, selected data and conflict. Storage, flags and read registers stay in reg_bank.

## Test plan
- Reset then idle: rst low 10 ns, then high. Read all addresses → rd_data 0, rd_vld 0, wr_conflict 0.
- Priority: NREGS=4, wr_addr=2, acc=0x0008, load=0x0006, se=0x0009, all three strobes high one cycle. Then read addr 2 → 0x0008, rd_vld 1; wr_conflict high exactly one cycle.
- Single sources: ldm only to addr 1 (0x0006), then lse only to addr 3 (0x0009). Port A reads 1 and port B reads 3 simultaneously → 0x0006 and 0x0009, both vld 1.
- Write-read collision: addr 0 holds 0x1111; write 0x2222 via lacc while rd_addr_a=0 on the same edge.
  - Without macro → 0x1111, then 0x2222 next cycle.
  - With REG_BANK_BYPASS_EN → 0x2222 immediately.
- Out of range: NREGS=3, write 0xBEEF to addr 3 → no entry changes. Read addr 3 → 0x0000, vld 0.
- Async reset mid-operation: entries loaded with nonzero values, rst pulsed low between clock edges. All outputs go to 0 before the next edge, and all flags read 0 afterwards.
